// File: rtl/alu.sv
// 32-bit ALU: seven combinational ops plus an optional multi-cycle
// unsigned MOD unit (restoring shift-subtract, 32 cycles per result).
//
// Build option: define ALU_MOD_EN to include the MOD unit. Without it,
// ALUop 111 returns 0, start is ignored and done is tied high.
//
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   start  - MOD launch request (only honoured with ALUop 111 in IDLE)
//   A, B   - 32-bit operands
//   ALUop  - 000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT,
//            101 ADD, 110 SUB, 111 MOD (remainder register)
//   Result - operation result
//   done   - high when the MOD unit is idle / its result is valid
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUop,
    output logic [31:0] Result,
    output logic        done
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    logic [31:0] mod_res;
    logic        slt;

    assign slt = $signed(A) < $signed(B);

`ifdef ALU_MOD_EN

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]  state_q;
    logic [4:0]  cnt_q;
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic [31:0] part_q;
    logic [31:0] rem_q;

    logic [32:0] r_sh;
    logic [32:0] sub;
    logic        ge;
    logic [31:0] part_nxt;
    logic        unused_mod;

    // One restoring step: bring in the next dividend bit, subtract the
    // divisor if it fits. r_sh is 33 bits so the compare never wraps.
    assign r_sh     = {part_q, dvd_q[31]};
    assign sub      = r_sh - {1'b0, dvs_q};
    assign ge       = r_sh >= {1'b0, dvs_q};
    assign part_nxt = ge ? sub[31:0] : r_sh[31:0];

    // With a zero divisor the top bit of sub is simply dropped; the
    // partial remainder then just accumulates the dividend.
    assign unused_mod = sub[32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            part_q  <= 32'd0;
            rem_q   <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && (ALUop == OP_MOD)) begin
                        dvd_q   <= A;
                        dvs_q   <= B;
                        part_q  <= 32'd0;
                        cnt_q   <= 5'd0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    part_q <= part_nxt;
                    dvd_q  <= {dvd_q[30:0], 1'b0};
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        rem_q   <= part_nxt;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mod_res = rem_q;
    assign done    = (state_q == IDLE);

`else

    logic unused_nomod;

    assign unused_nomod = ^{clk, rst_n, start};
    assign mod_res      = 32'd0;
    assign done         = 1'b1;

`endif

    always_comb begin
        Result = 32'd0;
        unique case (ALUop)
            OP_AND:  Result = A & B;
            OP_OR:   Result = A | B;
            OP_XOR:  Result = A ^ B;
            OP_NOR:  Result = ~(A | B);
            OP_SLT:  Result = {31'd0, slt};
            OP_ADD:  Result = A + B;
            OP_SUB:  Result = A - B;
            OP_MOD:  Result = mod_res;
            default: Result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed vectors, scoreboard queue checked by
// an independent monitor on the falling clock edge.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [2:0]  ALUop = 3'b000;
    logic [31:0] Result;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic        exp_done;
        int          lat;
        logic [31:0] prev;
    } exp_t;

    exp_t sb[$];

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (A),
        .B      (B),
        .ALUop  (ALUop),
        .Result (Result),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: lat==0 entries are sampled at the next falling edge;
    // lat>0 entries count done-low cycles, then check the result.
    initial begin
        int   busy;
        int   waitc;
        exp_t e;
        busy  = 0;
        waitc = 0;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb[0];
                if (e.lat == 0) begin
                    chk(e.name, Result, e.exp);
                    chk({e.name, "_done"}, {31'd0, done},
                        {31'd0, e.exp_done});
                    void'(sb.pop_front());
                end else if (!done) begin
                    busy++;
                    if (busy == 1)
                        chk({e.name, "_hold"}, Result, e.prev);
                    if (busy > 100) begin
                        chk({e.name, "_stuck"}, 32'(busy), 32'(e.lat));
                        void'(sb.pop_front());
                        busy = 0;
                    end
                end else if (busy > 0) begin
                    chk({e.name, "_lat"}, 32'(busy), 32'(e.lat));
                    chk(e.name, Result, e.exp);
                    void'(sb.pop_front());
                    busy  = 0;
                    waitc = 0;
                end else begin
                    waitc++;
                    if (waitc > 4) begin
                        chk({e.name, "_nostart"}, {31'd0, done}, 32'd0);
                        void'(sb.pop_front());
                        waitc = 0;
                    end
                end
            end
        end
    end

    task automatic wait_empty();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(posedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic comb(input string n, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] op,
                        input logic st, input logic [31:0] exp);
        @(posedge clk);
        #1;
        A     = a;
        B     = b;
        ALUop = op;
        start = st;
        sb.push_back('{n, exp, 1'b1, 0, 32'd0});
        wait_empty();
        start = 1'b0;
    endtask

`ifdef ALU_MOD_EN
    task automatic modop(input string n, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input logic [31:0] prev, input bit glitch);
        @(posedge clk);
        #1;
        A     = a;
        B     = b;
        ALUop = 3'b111;
        start = 1'b1;
        sb.push_back('{n, exp, 1'b1, 32, prev});
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = ~a;
        B     = 32'h0000_1234;
        if (glitch) begin
            repeat (5) @(posedge clk);
            #1;
            A     = 32'd3;
            B     = 32'd2;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_empty();
    endtask
`endif

    initial begin
        comb("rst_rem", 32'd0, 32'd0, 3'b111, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        comb("and", 32'hAAAAAA0F, 32'h5555551F, 3'b000, 1'b0, 32'h0000000F);
        comb("or",  32'hAAAAAA0F, 32'h5555551F, 3'b001, 1'b0, 32'hFFFFFF1F);
        comb("xor", 32'hAAAAAA0F, 32'h5555551F, 3'b010, 1'b0, 32'hFFFFFF10);
        comb("nor", 32'd0, 32'd0, 3'b011, 1'b0, 32'hFFFFFFFF);
        comb("slt1", 32'd15, 32'd20, 3'b100, 1'b0, 32'd1);
        comb("slt2", 32'd200, 32'd150, 3'b100, 1'b0, 32'd0);
        comb("slt3", 32'hFFFFFFFF, 32'd1, 3'b100, 1'b0, 32'd1);
        comb("slt4", 32'h80000000, 32'h7FFFFFFF, 3'b100, 1'b0, 32'd1);
        comb("add1", 32'd123, 32'd6, 3'b101, 1'b0, 32'd129);
        comb("add2", 32'd7, 32'd1, 3'b101, 1'b0, 32'd8);
        comb("add3", 32'hFFFFFFFF, 32'd1, 3'b101, 1'b0, 32'd0);
        comb("sub1", 32'd321, 32'd300, 3'b110, 1'b0, 32'd21);
        comb("sub2", 32'd2, 32'd4, 3'b110, 1'b0, 32'hFFFFFFFE);
        comb("st_add", 32'd40, 32'd2, 3'b101, 1'b1, 32'd42);

`ifdef ALU_MOD_EN
        modop("mod27_25", 32'd27, 32'd25, 32'd2, 32'd0, 1'b0);
        modop("mod23_14", 32'd23, 32'd14, 32'd9, 32'd2, 1'b0);
        modop("mod101_34", 32'd101, 32'd34, 32'd33, 32'd9, 1'b1);
        modop("mod24_8", 32'd24, 32'd8, 32'd0, 32'd33, 1'b0);
        modop("mod5_7", 32'd5, 32'd7, 32'd5, 32'd0, 1'b0);
        modop("modbig", 32'hFFFFFFFF, 32'd10, 32'd5, 32'd5, 1'b0);

        // Reset mid-operation
        @(posedge clk);
        #1;
        A     = 32'd1000;
        B     = 32'd3;
        ALUop = 3'b111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.push_back('{"rst_mid", 32'd0, 1'b1, 0, 32'd0});
        wait_empty();
        comb("rst_start", 32'd50, 32'd7, 3'b111, 1'b1, 32'd0);
        comb("rst_add", 32'd2, 32'd3, 3'b101, 1'b0, 32'd5);
        comb("rst_stay", 32'd50, 32'd7, 3'b111, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        modop("mod9_0", 32'd9, 32'd0, 32'd9, 32'd0, 1'b0);
        modop("mod7_7", 32'd7, 32'd7, 32'd0, 32'd9, 1'b0);
`else
        comb("nomod1", 32'd27, 32'd25, 3'b111, 1'b1, 32'd0);
        comb("nomod2", 32'd27, 32'd25, 3'b111, 1'b0, 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port start, input, 1 bit: MOD launch request, sampled on the rising edge of clk.
REQ-004 The block SHALL have the port A, input, 32 bits: operand A.
REQ-005 The block SHALL have the port B, input, 32 bits: operand B.
REQ-006 The block SHALL have the port ALUop, input, 3 bits: operation select.
REQ-007 The block SHALL have the port Result, output, 32 bits: operation result.
REQ-008 The block SHALL have the port done, output, 1 bit: high when the MOD unit is idle or its result is valid.

Function
REQ-009 ALUop 000..110 SHALL produce a purely combinational Result from the live A, B and ALUop, independent of clk, start and MOD state.
REQ-010 ALUop 000: Result = A AND B; 001: A OR B; 010: A XOR B; 011: NOT(A OR B), bitwise over 32 bits.
REQ-011 ALUop 100 (SLT): Result = 1 if A < B as signed two's-complement values, else 0; bits 31:1 are always 0.
REQ-012 ALUop 101: Result = (A + B) mod 2^32; 110: Result = (A - B) mod 2^32; there is no carry or overflow output.
REQ-013 ALUop 111 (MOD): Result SHALL equal the remainder register, which holds the last completed unsigned A mod B, or 0 after reset.
REQ-014 The MOD FSM SHALL have two states, IDLE (done=1) and BUSY (done=0).
REQ-015 In IDLE, a rising edge with start=1 and ALUop=111 SHALL latch A and B, clear the iteration counter and enter BUSY; start with any other ALUop SHALL be ignored.
REQ-016 BUSY SHALL perform one restoring shift-subtract division step per cycle for 32 cycles, keeping the partial remainder internally.
REQ-017 On the 32nd BUSY edge, the final remainder SHALL be written to the remainder register and the FSM SHALL return to IDLE (done=1); done is therefore low for exactly 32 cycles.
REQ-018 start, A, B and ALUop changes during BUSY SHALL NOT affect the computation in progress; start during BUSY SHALL be ignored.
REQ-019 The remainder register SHALL keep its previous value throughout BUSY.
REQ-020 Divisor 0 SHALL produce a remainder equal to the latched A, with normal 32-cycle latency.
REQ-021 A < B SHALL produce a remainder of A; A = B SHALL produce 0.

Reset
REQ-022 Asserting rst_n low SHALL immediately force IDLE, done=1, the remainder register to 0, and the counter and latched operands to 0, including mid-operation.
REQ-023 Combinational ops SHALL remain functional while reset is asserted; MOD starts SHALL be ignored until rst_n is high.

Configuration
REQ-024 When ALU_MOD_EN is defined, the MOD unit SHALL be built as specified above.
REQ-025 When ALU_MOD_EN is undefined, no MOD logic SHALL exist: ALUop 111 gives Result=0, start is ignored, and done is constant 1.

Verification (ALU_MOD_EN defined)
REQ-026 MOD: 27,25 -> 2; 23,14 -> 9; 101,34 -> 33; 24,8 -> 0; each case SHALL have done low for 32 cycles, then high.
REQ-027 Logic: A=0xAAAAAA0F, B=0x5555551F: op 000 -> 0x0000000F; op 011 with A=B=0 -> 0xFFFFFFFF.
REQ-028 SLT: 15,20 -> 1; 200,150 -> 0; 0xFFFFFFFF,1 -> 1 (signed).
REQ-029 Arithmetic: 123+6 -> 129; 7+1 -> 8; 321-300 -> 21; 2-4 -> 0xFFFFFFFE; 0xFFFFFFFF+1 -> 0.
REQ-030 Edge cases: MOD 9,0 -> 9; pulsing rst_n low 10 cycles into a MOD -> done=1 immediately and Result(op 111)=0; a start pulse during BUSY SHALL NOT extend latency.
